// File: rtl/user_rd_reg_pkg.sv
// Shared definitions for the JTAG user read register.
// USER_RD_REG_STATUS_EN adds FRESH/OVERRUN status bits ahead of the data word.
package user_rd_reg_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StShifting
    } state_e;

    localparam int unsigned DEF_WIDTH  = 16;
    localparam int unsigned STAT_FRESH = 0;
    localparam int unsigned STAT_OVR   = 1;
    localparam int unsigned STAT_BITS  = 2;

    // Number of TCK shifts that make up a full read.
    function automatic int unsigned shift_len(input int unsigned width);
`ifdef USER_RD_REG_STATUS_EN
        return width + STAT_BITS;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/user_rd_hold.sv
// Fabric-side holding register: hold/pend buffering, FRESH and OVERRUN tracking.
// USER_RD_REG_STATUS_EN lets a completed read clear OVERRUN.
module user_rd_hold
    import user_rd_reg_pkg::*;
#(
    parameter int unsigned      WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] DEF_VALUE = '0
) (
    input  logic             TCK,
    input  logic             RST,
    input  logic [WIDTH-1:0] PI,
    input  logic             PI_STB,
    input  logic             busy,
    input  logic             rd_done,
    output logic [WIDTH-1:0] hold,
    output logic             fresh,
    output logic             overrun
);

    logic [WIDTH-1:0] hold_q;
    logic [WIDTH-1:0] pend_q;
    logic             pend_vld_q;
    logic             fresh_q;
    logic             ovr_q;

    always_ff @(posedge TCK or negedge RST) begin
        if (!RST) begin
            hold_q     <= DEF_VALUE;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            fresh_q    <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            // Clears come first so a same-cycle overrun still sticks.
            if (rd_done) begin
                fresh_q <= 1'b0;
`ifdef USER_RD_REG_STATUS_EN
                ovr_q   <= 1'b0;
`endif
            end
            if (PI_STB && !busy) begin
                hold_q     <= PI;
                fresh_q    <= 1'b1;
                pend_vld_q <= 1'b0;
                if (fresh_q || pend_vld_q) ovr_q <= 1'b1;
            end else if (PI_STB) begin
                pend_q     <= PI;
                pend_vld_q <= 1'b1;
                if (pend_vld_q) ovr_q <= 1'b1;
            end else if (!busy && pend_vld_q) begin
                hold_q     <= pend_q;
                fresh_q    <= 1'b1;
                pend_vld_q <= 1'b0;
            end
        end
    end

    assign hold    = hold_q;
    assign fresh   = fresh_q;
    assign overrun = ovr_q;

endmodule

// File: rtl/user_rd_reg.sv
// JTAG user read register: parallel-in from fabric, serial-out LSB-first on TDO/DSY_OUT.
// USER_RD_REG_STATUS_EN prepends {OVERRUN, FRESH} to the shifted word.
module user_rd_reg
    import user_rd_reg_pkg::*;
#(
    parameter int unsigned      WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] DEF_VALUE = '0
) (
    input  logic             TCK,
    input  logic             RST,
    input  logic             SEL,
    input  logic             FSEL,
    input  logic             DSY_CHAIN,
    input  logic             CAPTURE,
    input  logic             SHIFT,
    input  logic             UPDATE,
    input  logic             TDI,
    input  logic             DSY_IN,
    input  logic [WIDTH-1:0] PI,
    input  logic             PI_STB,
    output logic             TDO,
    output logic             DSY_OUT,
    output logic             BUSY,
    output logic             FRESH,
    output logic             OVERRUN,
    output logic             RD_ACK
);

    localparam int unsigned N  = shift_len(WIDTH);
    localparam int unsigned CW = $clog2(N + 1);
    localparam logic [CW-1:0] CntMax = CW'(N);
`ifdef USER_RD_REG_STATUS_EN
    localparam logic [N-1:0] SregRst = {DEF_VALUE, 2'b00};
`else
    localparam logic [N-1:0] SregRst = DEF_VALUE;
`endif

    state_e           state_q;
    logic [N-1:0]     sreg_q;
    logic [N-1:0]     cap_val;
    logic [CW-1:0]    cnt_q;
    logic             rd_ack_q;
    logic             act;
    logic             din;
    logic             rd_done;
    logic             busy;
    logic             fresh;
    logic             overrun;
    logic [WIDTH-1:0] hold;

    assign act  = SEL & (FSEL | DSY_CHAIN);
    assign din  = DSY_CHAIN ? DSY_IN : TDI;
    assign busy = (state_q == StShifting);

    always_comb begin
        cap_val = '0;
`ifdef USER_RD_REG_STATUS_EN
        cap_val[N-1:STAT_BITS] = hold;
        cap_val[STAT_FRESH]    = fresh;
        cap_val[STAT_OVR]      = overrun;
`else
        cap_val = hold;
`endif
    end

    // Full-length UPDATE; CAPTURE and SHIFT outrank UPDATE in the same cycle.
    assign rd_done = busy & act & ~CAPTURE & ~SHIFT & UPDATE & (cnt_q == CntMax);

    always_ff @(posedge TCK or negedge RST) begin
        if (!RST) begin
            state_q  <= StIdle;
            sreg_q   <= SregRst;
            cnt_q    <= '0;
            rd_ack_q <= 1'b0;
        end else begin
            rd_ack_q <= rd_done;
            case (state_q)
                StIdle: begin
                    if (CAPTURE && act) begin
                        sreg_q  <= cap_val;
                        cnt_q   <= '0;
                        state_q <= StShifting;
                    end
                end
                StShifting: begin
                    if (!SEL) begin
                        state_q <= StIdle;
                    end else if (CAPTURE && act) begin
                        sreg_q <= cap_val;
                        cnt_q  <= '0;
                    end else if (SHIFT && act) begin
                        sreg_q <= {din, sreg_q[N-1:1]};
                        if (cnt_q != CntMax) cnt_q <= cnt_q + CW'(1);
                    end else if (UPDATE && act) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    user_rd_hold #(
        .WIDTH     (WIDTH),
        .DEF_VALUE (DEF_VALUE)
    ) u_hold (
        .TCK     (TCK),
        .RST     (RST),
        .PI      (PI),
        .PI_STB  (PI_STB),
        .busy    (busy),
        .rd_done (rd_done),
        .hold    (hold),
        .fresh   (fresh),
        .overrun (overrun)
    );

    assign TDO     = FSEL & sreg_q[0];
    assign DSY_OUT = DSY_CHAIN & sreg_q[0];
    assign BUSY    = busy;
    assign FRESH   = fresh;
    assign OVERRUN = overrun;
    assign RD_ACK  = rd_ack_q;

endmodule

// File: tb/tb_user_rd_reg.sv
// Bench for user_rd_reg: queue-based read model checked every cycle, plus directed
// literal checks. Define USER_RD_REG_STATUS_EN to run the status-bit scenario.
module tb_user_rd_reg;

`ifdef USER_RD_REG_STATUS_EN
    localparam int MN = 18;
`else
    localparam int MN = 16;
`endif

    logic        TCK = 1'b0;
    logic        RST = 1'b1;
    logic        SEL = 1'b0, FSEL = 1'b0, DSY_CHAIN = 1'b0;
    logic        CAPTURE = 1'b0, SHIFT = 1'b0, UPDATE = 1'b0;
    logic        TDI = 1'b0, DSY_IN = 1'b0;
    logic [15:0] PI = '0;
    logic        PI_STB = 1'b0;
    logic        TDO, DSY_OUT, BUSY, FRESH, OVERRUN, RD_ACK;

    int n_chk  = 0;
    int n_pass = 0;
    bit started = 1'b0;

    user_rd_reg dut (
        .TCK       (TCK),
        .RST       (RST),
        .SEL       (SEL),
        .FSEL      (FSEL),
        .DSY_CHAIN (DSY_CHAIN),
        .CAPTURE   (CAPTURE),
        .SHIFT     (SHIFT),
        .UPDATE    (UPDATE),
        .TDI       (TDI),
        .DSY_IN    (DSY_IN),
        .PI        (PI),
        .PI_STB    (PI_STB),
        .TDO       (TDO),
        .DSY_OUT   (DSY_OUT),
        .BUSY      (BUSY),
        .FRESH     (FRESH),
        .OVERRUN   (OVERRUN),
        .RD_ACK    (RD_ACK)
    );

    always #5 TCK = ~TCK;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    bit          m_busy, m_fresh, m_ovr, m_ack, m_pend_vld;
    logic [15:0] m_hold, m_pend;
    int          m_cnt;
    bit          m_bits[$];
    bit          m_act, m_din, m_full, m_was_busy;

    function automatic void m_load();
        m_bits.delete();
`ifdef USER_RD_REG_STATUS_EN
        m_bits.push_back(m_fresh);
        m_bits.push_back(m_ovr);
`endif
        for (int i = 0; i < 16; i++) m_bits.push_back(m_hold[i]);
    endfunction

    always @(posedge TCK or negedge RST) begin
        if (!RST) begin
            m_busy = 0; m_fresh = 0; m_ovr = 0; m_ack = 0; m_pend_vld = 0;
            m_hold = '0; m_pend = '0; m_cnt = 0;
            m_bits.delete();
            for (int i = 0; i < MN; i++) m_bits.push_back(1'b0);
        end else begin
            m_act      = SEL && (FSEL || DSY_CHAIN);
            m_din      = DSY_CHAIN ? DSY_IN : TDI;
            m_full     = 0;
            m_was_busy = m_busy;
            if (!m_busy) begin
                if (CAPTURE && m_act) begin m_load(); m_cnt = 0; m_busy = 1; end
            end else if (!SEL) begin
                m_busy = 0;
            end else if (CAPTURE && m_act) begin
                m_load(); m_cnt = 0;
            end else if (SHIFT && m_act) begin
                void'(m_bits.pop_front());
                m_bits.push_back(m_din);
                if (m_cnt < MN) m_cnt++;
            end else if (UPDATE && m_act) begin
                m_full = (m_cnt == MN);
                m_busy = 0;
            end
            if (m_full) begin
                m_fresh = 0;
`ifdef USER_RD_REG_STATUS_EN
                m_ovr = 0;
`endif
            end
            if (PI_STB && !m_was_busy) begin
                if (m_fresh || m_pend_vld) m_ovr = 1;
                m_hold = PI; m_fresh = 1; m_pend_vld = 0;
            end else if (PI_STB) begin
                if (m_pend_vld) m_ovr = 1;
                m_pend = PI; m_pend_vld = 1;
            end else if (!m_was_busy && m_pend_vld) begin
                m_hold = m_pend; m_fresh = 1; m_pend_vld = 0;
            end
            m_ack = m_full;
        end
    end

    always @(negedge TCK) begin
        if (started) begin
            chk("tdo", TDO, FSEL & m_bits[0]);
            chk("dsy_out", DSY_OUT, DSY_CHAIN & m_bits[0]);
            chk("busy", BUSY, m_busy);
            chk("fresh", FRESH, m_fresh);
            chk("overrun", OVERRUN, m_ovr);
            chk("rd_ack", RD_ACK, m_ack);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge TCK);
        #1;
    endtask

    task automatic strobe(input logic [15:0] v);
        PI = v; PI_STB = 1'b1;
        tick();
        PI_STB = 1'b0;
    endtask

    // Capture then nsh shifts; acc[k] holds the serial outputs seen after shift k.
    task automatic do_read(input int nsh, input int s1, input logic [15:0] v1,
                           input int s2, input logic [15:0] v2,
                           output logic [63:0] tacc, output logic [63:0] dacc);
        tacc = '0; dacc = '0;
        CAPTURE = 1'b1;
        tick();
        CAPTURE = 1'b0;
        tacc[0] = TDO; dacc[0] = DSY_OUT;
        for (int k = 1; k <= nsh; k++) begin
            SHIFT = 1'b1;
            if (k == s1) begin PI = v1; PI_STB = 1'b1; end
            if (k == s2) begin PI = v2; PI_STB = 1'b1; end
            tick();
            SHIFT = 1'b0; PI_STB = 1'b0;
            tacc[k] = TDO; dacc[k] = DSY_OUT;
        end
    endtask

    task automatic do_update();
        UPDATE = 1'b1;
        tick();
        UPDATE = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    logic [63:0] ta, da;

    initial begin
        #3 RST = 1'b0;
        #1 started = 1'b1;
        chk("reset_tdo", TDO, 1'b0);
        chk("reset_busy", BUSY, 1'b0);
        chk("reset_fresh", FRESH, 1'b0);
        chk("reset_ovr", OVERRUN, 1'b0);
        chk("reset_ack", RD_ACK, 1'b0);
        tick(); tick();
        RST = 1'b1;
        SEL = 1'b1; FSEL = 1'b1;
        tick();

`ifndef USER_RD_REG_STATUS_EN
        // 1. basic full read
        strobe(16'hA5C3);
        chk("t1_fresh_set", FRESH, 1'b1);
        do_read(16, -1, '0, -1, '0, ta, da);
        chk("t1_tdo_word", ta[15:0], 16'hA5C3);
        chk("t1_tdo_first", ta[0], 1'b1);
        do_update();
        chk("t1_ack", RD_ACK, 1'b1);
        chk("t1_fresh_clr", FRESH, 1'b0);
        tick();
        chk("t1_ack_pulse", RD_ACK, 1'b0);

        // 2. short read leaves the word unread
        strobe(16'hA5C3);
        do_read(8, -1, '0, -1, '0, ta, da);
        do_update();
        chk("t2_no_ack", RD_ACK, 1'b0);
        tick();
        chk("t2_no_ack2", RD_ACK, 1'b0);
        chk("t2_fresh", FRESH, 1'b1);
        do_read(16, -1, '0, -1, '0, ta, da);
        chk("t2_reread", ta[15:0], 16'hA5C3);
        do_update();
        chk("t2_ack", RD_ACK, 1'b1);
        tick();

        // 3. strobes arriving mid-read
        strobe(16'hBEEF);
        do_read(16, 4, 16'h1234, -1, '0, ta, da);
        chk("t3_old_word", ta[15:0], 16'hBEEF);
        chk("t3_no_ovr", OVERRUN, 1'b0);
        do_update();
        tick();
        chk("t3_fresh_pend", FRESH, 1'b1);
        do_read(16, 3, 16'h1111, 9, 16'h5678, ta, da);
        chk("t3_pend_word", ta[15:0], 16'h1234);
        chk("t3_ovr", OVERRUN, 1'b1);
        do_update();
        tick();
        do_read(16, -1, '0, -1, '0, ta, da);
        chk("t3_newest", ta[15:0], 16'h5678);
        do_update();
        tick();

        // 4. daisy chain
        FSEL = 1'b0; DSY_CHAIN = 1'b1; DSY_IN = 1'b1;
        do_read(32, -1, '0, -1, '0, ta, da);
        chk("t4_tdo_quiet", ta, 64'h0);
        chk("t4_dsy_word", da[15:0], 16'h5678);
        chk("t4_sreg_ones", da[31:16], 16'hFFFF);
        do_update();
        chk("t4_ack", RD_ACK, 1'b1);
        DSY_CHAIN = 1'b0; DSY_IN = 1'b0; FSEL = 1'b1;
        tick();

        // 5. asynchronous reset mid-shift, then SEL abort
        strobe(16'h00FF);
        do_read(3, -1, '0, -1, '0, ta, da);
        chk("t5_pre_tdo", TDO, 1'b1);
        #2 RST = 1'b0;
        #1;
        chk("t5_rst_tdo", TDO, 1'b0);
        chk("t5_rst_busy", BUSY, 1'b0);
        chk("t5_rst_fresh", FRESH, 1'b0);
        tick();
        RST = 1'b1;
        tick();
        strobe(16'h0F0F);
        do_read(5, -1, '0, -1, '0, ta, da);
        SEL = 1'b0;
        tick();
        chk("t5_abort_busy", BUSY, 1'b0);
        do_update();
        chk("t5_abort_noack", RD_ACK, 1'b0);
        tick();
        chk("t5_abort_fresh", FRESH, 1'b1);
        SEL = 1'b1;
        do_read(16, -1, '0, -1, '0, ta, da);
        chk("t5_after_abort", ta[15:0], 16'h0F0F);
        do_update();
        chk("t5_ack", RD_ACK, 1'b1);
        tick();
`else
        // 6. status bits ahead of the data
        strobe(16'h0002);
        strobe(16'h0001);
        chk("t6_ovr_set", OVERRUN, 1'b1);
        chk("t6_fresh_set", FRESH, 1'b1);
        do_read(17, -1, '0, -1, '0, ta, da);
        chk("t6_first_bits", ta[3:0], 4'b0111);
        chk("t6_data", ta[17:2], 16'h0001);
        do_update();
        chk("t6_short_noack", RD_ACK, 1'b0);
        chk("t6_ovr_kept", OVERRUN, 1'b1);
        tick();
        do_read(18, -1, '0, -1, '0, ta, da);
        chk("t6_full_bits", ta[17:0], 18'b00_0000_0000_0000_0111);
        do_update();
        chk("t6_ack", RD_ACK, 1'b1);
        chk("t6_ovr_clr", OVERRUN, 1'b0);
        chk("t6_fresh_clr", FRESH, 1'b0);
        tick();
        chk("t6_ack_pulse", RD_ACK, 1'b0);
`endif
        tick(); tick();
        started = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
